alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/datapath width in bits, used only for opnd_data and its checks.
REQ-002 SHALL have parameter MC_CYCLES, default 8: EXEC length for multi-cycle ops; legal range 2..15.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have cmd_valid in 1 / cmd_ready out 1 / cmd_op in 4: opcode handshake.
REQ-006 SHALL have opnd_valid in 1 / opnd_ready out 1 / opnd_data in WIDTH: operand beat handshake; data is routed by the datapath, not stored here.
REQ-007 SHALL have ld_a out 1, ld_b out 1, ld_res out 1: one-cycle load strobes to operand A, operand B and result registers.
REQ-008 SHALL have alu_op out 4: latched opcode to the ALU; alu_step out 1: ALU iteration enable.
REQ-009 SHALL have res_valid out 1 / res_ready in 1: result handshake; busy out 1; err out 1: illegal-opcode pulse.

Function
REQ-010 SHALL implement FSM states IDLE, GET_A, GET_B, EXEC, HOLD.
REQ-011 Opcode classes SHALL be: 0x0-0x7 binary single-cycle; 0x8 unary single-cycle (NOT); 0x9 MUL and 0xA DIV binary multi-cycle; 0xB-0xF illegal.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, legal op latches alu_op and goes GET_A; illegal op pulses err for 1 cycle, leaves alu_op unchanged, stays IDLE.
REQ-013 GET_A: opnd_ready=1; on opnd_valid, ld_a=1 that same cycle; next state GET_B (binary) or EXEC (unary).
REQ-014 GET_B: opnd_ready=1; on opnd_valid, ld_b=1 that same cycle; next state EXEC.
REQ-015 On EXEC entry the cycle counter SHALL load 1 (single-cycle) or MC_CYCLES (multi-cycle).
REQ-016 EXEC: alu_step=1 every cycle; counter decrements; in the cycle the counter equals 1, ld_res=1 and next state HOLD.
REQ-017 HOLD: res_valid=1 until res_ready sampled high, then IDLE; res_valid SHALL NOT drop before acceptance.
REQ-018 opnd_ready SHALL be 0 in IDLE, EXEC, HOLD; operand beats offered then are ignored (not consumed).
REQ-019 cmd_ready SHALL be 0 in every state except IDLE; a cmd_valid in the HOLD cycle where res_ready=1 is accepted no earlier than the next cycle.
REQ-020 busy SHALL equal (state != IDLE); all strobes are Moore/Mealy-combinational from state and handshake inputs, no extra latency.
REQ-021 Minimum latency, binary single-cycle op with back-to-back beats: cmd accepted cycle 0, ld_a cycle 1, ld_b cycle 2, ld_res cycle 3, res_valid from cycle 4.
REQ-022 Multi-cycle op: ld_res exactly MC_CYCLES cycles after EXEC entry minus 1, alu_step high for MC_CYCLES cycles.
REQ-023 Counter width SHALL be 4 bits; no wrap-around permitted (never decremented at 0).

Reset
REQ-024 rst high SHALL immediately force IDLE, counter 0, alu_op 0x0, and ld_a, ld_b, ld_res, alu_step, err, res_valid, busy all 0, in any state including mid-EXEC.
REQ-025 After rst release, cmd_ready SHALL be 1 from the first clock edge; no pending operation resumes.

Structure
REQ-026 Package alu_seq_pkg SHALL hold state encoding, opcode constants, opcode-class decode function and MC_CYCLES range limits.
REQ-027 Sub-module alu_exec_counter (load/decrement, is_one flag, async reset) SHALL implement the EXEC counter; FSM stays in alu_seq_ctrl.

Verification
REQ-028 ADD 0x0, beats 0x12 then 0x34, res_ready=1 -> ld_a cycle 1, ld_b cycle 2, ld_res cycle 3, res_valid cycle 4 only, busy cycles 1-4.
REQ-029 NOT 0x8, one beat -> ld_b never asserted, ld_res one cycle after ld_a, alu_step high 1 cycle.
REQ-030 MUL 0x9, MC_CYCLES=8 -> alu_step high 8 consecutive cycles, ld_res in the 8th, then res_valid.
REQ-031 Illegal 0xC -> err pulse 1 cycle, cmd_ready stays 1, alu_op unchanged, busy 0.
REQ-032 res_ready held low 5 cycles in HOLD with cmd_valid high -> res_valid steady, cmd_ready 0; cmd accepted cycle after res_ready.
REQ-033 rst pulsed mid-EXEC of DIV -> all outputs reset asynchronously, no ld_res, new command accepted after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, opcode constants,
// opcode-class decode and the legal range of the multi-cycle EXEC length.
package alu_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GET_A = 3'd1;
  localparam logic [2:0] ST_GET_B = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam logic [3:0] OP_LAST_BIN = 4'h7;
  localparam logic [3:0] OP_NOT      = 4'h8;
  localparam logic [3:0] OP_MUL      = 4'h9;
  localparam logic [3:0] OP_DIV      = 4'hA;

  localparam int unsigned MC_CYCLES_MIN = 2;
  localparam int unsigned MC_CYCLES_MAX = 15;

  typedef enum logic [1:0] {
    CLS_BIN_SC  = 2'd0,
    CLS_UN_SC   = 2'd1,
    CLS_BIN_MC  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    if (op <= OP_LAST_BIN)             return CLS_BIN_SC;
    else if (op == OP_NOT)             return CLS_UN_SC;
    else if (op == OP_MUL || op == OP_DIV) return CLS_BIN_MC;
    else                               return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_exec_counter.sv
// EXEC-phase cycle counter: loads a length, counts down, and flags the last
// cycle. Saturates at zero so it can never wrap.
module alu_exec_counter
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       is_one_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign is_one_o = (cnt_q == 4'd1);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Control sequencer for a simple ALU: accepts an opcode, collects one or two
// operand beats, runs the ALU for 1 or MC_CYCLES cycles, then holds the result.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MC_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             opnd_valid,
  output logic             opnd_ready,
  input  logic [WIDTH-1:0] opnd_data,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_res,
  output logic [3:0]       alu_op,
  output logic             alu_step,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);

  if (MC_CYCLES < MC_CYCLES_MIN || MC_CYCLES > MC_CYCLES_MAX) begin : g_mc_range
    $error("alu_seq_ctrl: MC_CYCLES outside 2..15");
  end

  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES);

  logic [2:0] state_q, state_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic       cnt_load, cnt_is_one;
  logic [3:0] cnt_load_val;

  // Operand data flows straight to the datapath; it never affects sequencing.
  logic unused_opnd;
  assign unused_opnd = ^opnd_data;

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    cmd_ready    = 1'b0;
    opnd_ready   = 1'b0;
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    ld_res       = 1'b0;
    alu_step     = 1'b0;
    res_valid    = 1'b0;
    err          = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = (op_class(alu_op_q) == CLS_BIN_MC) ? MC_LOAD : 4'd1;
    // The IDLE handshake is suppressed while rst is held so err cannot pulse.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            if (op_class(cmd_op) == CLS_ILLEGAL) begin
              err = 1'b1;
            end else begin
              alu_op_d = cmd_op;
              state_d  = ST_GET_A;
            end
          end
        end
        ST_GET_A: begin
          opnd_ready = 1'b1;
          if (opnd_valid) begin
            ld_a = 1'b1;
            if (op_class(alu_op_q) == CLS_UN_SC) begin
              cnt_load = 1'b1;
              state_d  = ST_EXEC;
            end else begin
              state_d  = ST_GET_B;
            end
          end
        end
        ST_GET_B: begin
          opnd_ready = 1'b1;
          if (opnd_valid) begin
            ld_b     = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_step = 1'b1;
          if (cnt_is_one) begin
            ld_res  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          res_valid = 1'b1;
          if (res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

  alu_exec_counter u_exec_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (alu_step),
    .is_one_o   (cnt_is_one)
  );

  assign alu_op = alu_op_q;
  assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed scenarios plus a randomized
// run, all compared against a transaction-level model of the sequencer.
module tb_alu_seq_ctrl;

  localparam int unsigned W  = 8;
  localparam int          MC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready;
  logic [3:0]   cmd_op;
  logic         opnd_valid, opnd_ready;
  logic [W-1:0] opnd_data;
  logic         ld_a, ld_b, ld_res, alu_step, res_valid, res_ready, busy, err;
  logic [3:0]   alu_op;
  logic [12:0]  obs;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W), .MC_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready), .opnd_data(opnd_data),
    .ld_a(ld_a), .ld_b(ld_b), .ld_res(ld_res), .alu_op(alu_op),
    .alu_step(alu_step), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .err(err)
  );

  assign obs = {cmd_ready, opnd_ready, ld_a, ld_b, ld_res, alu_step,
                res_valid, busy, err, alu_op};

  // Transaction model: a command is either absent, waiting for operand beats,
  // executing for a number of cycles, or holding its result.
  bit         m_busy, m_hold;
  int         m_beats_left, m_beats_taken, m_exec_left;
  logic [3:0] m_op;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_hold = 0; m_beats_left = 0; m_beats_taken = 0;
      m_exec_left = 0; m_op = 4'h0;
    end else if (!m_busy) begin
      if (cmd_valid && cmd_op <= 4'hA) begin
        m_busy = 1; m_op = cmd_op; m_beats_taken = 0;
        m_beats_left = (cmd_op == 4'h8) ? 1 : 2;
      end
    end else if (m_beats_left > 0) begin
      if (opnd_valid) begin
        m_beats_taken++; m_beats_left--;
        if (m_beats_left == 0) m_exec_left = (m_op >= 4'h9) ? MC : 1;
      end
    end else if (m_exec_left > 0) begin
      m_exec_left--;
      if (m_exec_left == 0) m_hold = 1;
    end else if (m_hold && res_ready) begin
      m_hold = 0; m_busy = 0;
    end
  end

  function automatic logic [12:0] model_out();
    logic cr, orr, la, lb, lr, st, rv, bz, er;
    if (rst) return '0;
    cr  = !m_busy;
    er  = !m_busy && cmd_valid && (cmd_op >= 4'hB);
    orr = m_beats_left > 0;
    la  = orr && opnd_valid && m_beats_taken == 0;
    lb  = orr && opnd_valid && m_beats_taken == 1;
    st  = m_exec_left > 0;
    lr  = m_exec_left == 1;
    rv  = m_hold;
    bz  = m_busy;
    return {cr, orr, la, lb, lr, st, rv, bz, er, m_op};
  endfunction

  task automatic drive_quiet();
    cmd_valid = 0; cmd_op = 4'h0; opnd_valid = 0; opnd_data = '0; res_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; cmd_valid = 1; cmd_op = 4'hC; opnd_valid = 1; opnd_data = 8'hAA; res_ready = 1;
    @(negedge clk); #1;
    checks++;
    if (obs !== 13'h0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, 13'h0);
    end
    @(negedge clk);
    rst = 0; drive_quiet();
    #1; checks++;
    if (obs !== model_out() || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs, model_out());
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    int la = -1, lb = -1, lr = -1, rv_first = -1, rv_n = 0, bz_n = 0;
    for (int c = 0; c < 6; c++) begin
      cmd_valid = (c == 0); cmd_op = 4'h0; res_ready = 1;
      opnd_valid = (c == 1 || c == 2); opnd_data = (c == 1) ? 8'h12 : 8'h34;
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL add_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      if (ld_a) la = c;
      if (ld_b) lb = c;
      if (ld_res) lr = c;
      if (res_valid) begin if (rv_first < 0) rv_first = c; rv_n++; end
      if (busy) bz_n++;
      @(negedge clk);
    end
    checks++;
    if ({8'(la), 8'(lb), 8'(lr), 8'(rv_first)} !== 32'h01020304) begin
      errors++; $display("FAIL add_latency: got a=%0d b=%0d res=%0d rv=%0d expected 1 2 3 4", la, lb, lr, rv_first);
    end
    checks++;
    if (rv_n != 1 || bz_n != 4) begin
      errors++; $display("FAIL add_durations: got rv=%0d busy=%0d expected rv=1 busy=4", rv_n, bz_n);
    end
    drive_quiet();
  endtask

  task automatic test_not();
    int la = -1, lb_n = 0, lr = -1, st_n = 0;
    for (int c = 0; c < 5; c++) begin
      cmd_valid = (c == 0); cmd_op = 4'h8; res_ready = 1;
      opnd_valid = (c >= 1); opnd_data = 8'h5A;
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL not_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      if (ld_a) la = c;
      if (ld_b) lb_n++;
      if (ld_res) lr = c;
      if (alu_step) st_n++;
      @(negedge clk);
    end
    checks++;
    if (lb_n != 0 || lr != la + 1 || st_n != 1 || la != 1) begin
      errors++; $display("FAIL not_shape: got ld_a=%0d ld_b_n=%0d ld_res=%0d steps=%0d expected 1 0 2 1", la, lb_n, lr, st_n);
    end
    drive_quiet();
  endtask

  task automatic test_mul();
    int st_first = -1, st_last = -1, st_n = 0, lr = -1, rv = -1;
    for (int c = 0; c < 13; c++) begin
      cmd_valid = (c == 0); cmd_op = 4'h9; res_ready = 1;
      opnd_valid = (c == 1 || c == 2); opnd_data = 8'(c * 7);
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL mul_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      if (alu_step) begin if (st_first < 0) st_first = c; st_last = c; st_n++; end
      if (ld_res) lr = c;
      if (res_valid && rv < 0) rv = c;
      @(negedge clk);
    end
    checks++;
    if (st_n != MC || st_last - st_first + 1 != MC || lr != st_last || rv != lr + 1) begin
      errors++; $display("FAIL mul_exec: got steps=%0d span=%0d..%0d ld_res=%0d rv=%0d expected %0d steps ending at ld_res", st_n, st_first, st_last, lr, rv, MC);
    end
    drive_quiet();
  endtask

  task automatic test_illegal();
    cmd_valid = 1; cmd_op = 4'hC;
    #1; checks++;
    if (obs !== model_out() || {err, cmd_ready, busy} !== 3'b110) begin
      errors++; $display("FAIL illegal_pulse: got %b expected %b", obs, model_out());
    end
    @(negedge clk);
    cmd_valid = 0;
    #1; checks++;
    if (obs !== model_out() || alu_op !== 4'h9 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL illegal_after: got %b expected %b", obs, model_out());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_hold();
    int rv_n = 0, cr_first = -1;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (c == 0) || (c >= 4); cmd_op = (c == 0) ? 4'h3 : 4'h1;
      opnd_valid = (c == 1 || c == 2); opnd_data = 8'h77;
      res_ready = (c == 9);
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL hold_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      if (c >= 4 && c <= 9 && res_valid) rv_n++;
      if (c >= 4 && cmd_ready && cr_first < 0) cr_first = c;
      @(negedge clk);
    end
    checks++;
    if (rv_n != 6 || cr_first != 10 || alu_op !== 4'h1) begin
      errors++; $display("FAIL hold_backpressure: got rv=%0d cmd_ready_at=%0d op=%h expected 6 10 1", rv_n, cr_first, alu_op);
    end
    drive_quiet();
    opnd_valid = 1; res_ready = 1;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL hold_drain: got busy=%b expected 0", busy);
    end
    drive_quiet();
  endtask

  task automatic test_reset_mid_exec();
    int lr_n = 0;
    for (int c = 0; c < 5; c++) begin
      cmd_valid = (c == 0); cmd_op = 4'hA; res_ready = 1;
      opnd_valid = (c == 1 || c == 2); opnd_data = 8'h09;
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL div_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      @(negedge clk);
    end
    drive_quiet();
    #2 rst = 1;
    #1; checks++;
    if (obs !== 13'h0) begin
      errors++; $display("FAIL rst_async: got %b expected %b", obs, 13'h0);
    end
    @(negedge clk);
    rst = 0; cmd_valid = 1; cmd_op = 4'h0;
    #1; checks++;
    if (obs !== model_out() || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_new_cmd: got %b expected %b", obs, model_out());
    end
    @(negedge clk);
    cmd_valid = 0;
    for (int c = 0; c < 12; c++) begin
      #1; if (ld_res) lr_n++;
      @(negedge clk);
    end
    checks++;
    if (lr_n != 0 || busy !== 1'b1 || alu_op !== 4'h0) begin
      errors++; $display("FAIL rst_no_resume: got ld_res_n=%0d busy=%b op=%h expected 0 1 0", lr_n, busy, alu_op);
    end
    opnd_valid = 1; res_ready = 1;
    for (int c = 0; c < 20 && busy; c++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rst_drain: got busy=%b expected 0", busy);
    end
    drive_quiet();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      cmd_valid  = $urandom_range(0, 1) == 1;
      cmd_op     = 4'($urandom_range(0, 15));
      opnd_valid = $urandom_range(0, 1) == 1;
      opnd_data  = 8'($urandom);
      res_ready  = $urandom_range(0, 2) != 0;
      #1; checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random_cycle%0d: got %b expected %b", c, obs, model_out());
      end
      @(negedge clk);
    end
    rst = 0; drive_quiet();
  endtask

  initial begin
    drive_quiet();
    rst = 1;
    test_reset();
    test_add();
    test_not();
    test_mul();
    test_illegal();
    test_back_to_back_hold();
    test_reset_mid_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
